alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//   Command front-end and result back-end for the 8-bit combinational ALU.
//   Buffers {a, b, alu_sel, tag} commands from an upstream valid/ready producer in a FIFO,
//   drives the FIFO head onto the ALU operand/select inputs, registers alu_out with its tag,
//   and presents results to a downstream valid/ready consumer. Adds pipelining, backpressure and flush.
// PARAMETERS
//   DEPTH     4   command FIFO entries; power of two, >= 2
//   TAG_W     4   width of the per-command tag, returned with the result
//   NUM_OPS   9   legal opcodes are 0..NUM_OPS-1; sel >= NUM_OPS is flagged illegal
// PORTS
//   clk          in   1      single clock, rising edge
//   rst          in   1      asynchronous, active-high reset
//   cmd_valid    in   1      upstream command valid
//   cmd_ready    out  1      FIFO can accept (not full)
//   cmd_a        in   8      operand a
//   cmd_b        in   8      operand b
//   cmd_sel      in   4      ALU opcode
//   cmd_tag      in   TAG_W  command tag
//   alu_a        out  8      to ALU a; FIFO-head operand a
//   alu_b        out  8      to ALU b
//   alu_sel      out  4      to ALU alu_sel
//   alu_out      in   8      from ALU, combinational result of alu_a/alu_b/alu_sel
//   res_valid    out  1      result register holds a result
//   res_ready    in   1      downstream accepts result
//   res_data     out  8      registered ALU result (0 when illegal opcode)
//   res_tag      out  TAG_W  tag of the command that produced res_data
//   res_err      out  1      1 = opcode was >= NUM_OPS
//   flush        in   1      synchronous: drop all queued commands and the held result
//   issued_cnt   out  16     results produced since reset; wraps 0xFFFF -> 0
// BEHAVIOUR
//   Reset (async, rst=1): FIFO empty, wr/rd pointers 0, cmd_ready=1, res_valid=0, res_data=0,
//     res_tag=0, res_err=0, issued_cnt=0, alu_a/alu_b/alu_sel=0. A reset mid-operation discards everything.
//   Push: cmd_valid & cmd_ready at a rising edge writes the entry; cmd_ready = (count != DEPTH).
//     Push while full is not possible; cmd_ready is 0 and inputs are ignored.
//   ALU drive: alu_a/b/sel = FIFO head when not empty, else 0. alu_out is sampled in the same cycle.
//   Capture condition cap = !empty & (!res_valid | res_ready). On cap: pop head; res_data <= err ? 0 : alu_out;
//     res_tag <= head tag; res_err <= (head sel >= NUM_OPS); res_valid <= 1; issued_cnt += 1.
//   Drain: res_valid & res_ready & !cap -> res_valid <= 0. Hold: res_valid & !res_ready -> all res_* stable.
//   Latency: a command accepted at edge N into an empty FIFO with an idle output reg gives res_valid=1 after edge N+1.
//   Throughput: 1 result/cycle when res_ready stays high; no bubble on simultaneous pop and push.
//   Simultaneous push and pop when full: pop frees a slot, but cmd_ready is computed from the pre-edge count.
//     It is 0, so there is no push that cycle.
//   Simultaneous push and pop when empty: no pop (empty). The push lands and the entry is issued next cycle.
//   count tracks (pushes - pops); pointers are log2(DEPTH) bits and wrap naturally.
//   flush=1 at an edge: count <= 0, pointers <= 0, res_valid <= 0; push and cap are suppressed that cycle.
//     issued_cnt is not cleared.
//   Ordering: results leave strictly in command acceptance order.
//   Opcode table (ALU): 0 ADD, 1 SUB, 2 MUL(low 8), 3 SHL1, 4 SHR1, 5 ROL1, 6 ROR1, 7 AND, 8 OR; ADD/SUB wrap mod 256.
// TESTING
//   1 Reset: assert rst mid-stream with 3 queued -> res_valid=0, cmd_ready=1, issued_cnt=0 immediately, async.
//   2 Single op: push a=8'h0F, b=8'h01, sel=0, tag=3 with res_ready=1 -> edge+1: res_valid=1, res_data=8'h10, res_tag=3.
//   3 Wrap: push a=8'hFF, b=8'h02, sel=0 -> res_data=8'h01. Push a=8'h00, b=8'h01, sel=1 -> res_data=8'hFF.
//   4 Backpressure: res_ready=0, push 5 cmds (DEPTH=4) -> the 1st is held in the result reg and 4 fill the FIFO.
//     cmd_ready=0; then res_ready=1 gives 5 results, tags in order, one per cycle.
//   5 Illegal: push sel=4'hC, a=5, b=6 -> res_err=1, res_data=0. The next legal cmd gives res_err=0.
//   6 Flush: 3 queued + 1 held, pulse flush -> res_valid=0, cmd_ready=1, no stale result ever emitted.
//     issued_cnt is unchanged.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and result signals of the ALU command sequencer.
// The sequencer is the slave; the producer/consumer/ALU side is the master.
interface alu_cmd_sequencer_if #(
  parameter int unsigned TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [3:0]       cmd_sel;
  logic [TAG_W-1:0] cmd_tag;

  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [3:0]       alu_sel;
  logic [7:0]       alu_out;

  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;

  logic             flush;
  logic [15:0]      issued_cnt;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag, alu_out, res_ready, flush,
    output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_tag, res_err, issued_cnt
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag, alu_out, res_ready, flush,
    input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_tag, res_err, issued_cnt
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO in front of an external combinational ALU, with a registered
// valid/ready result stage, flush and a free-running issued-result counter.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned NUM_OPS = 9
) (
  input logic                clk,
  input logic                rst,
  alu_cmd_sequencer_if.slave bus
);
  localparam int unsigned     PtrW     = $clog2(DEPTH);
  localparam logic [PtrW:0]   DepthCnt = (PtrW + 1)'(DEPTH);
  localparam logic [PtrW:0]   CntOne   = (PtrW + 1)'(1);
  localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
  localparam logic [4:0]      NumOpsW  = 5'(NUM_OPS);

  typedef struct packed {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [3:0]       sel;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  cmd_t             mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;

  logic             res_valid_q, res_valid_d;
  logic [7:0]       res_data_q, res_data_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             res_err_q, res_err_d;
  logic [15:0]      issued_cnt_q, issued_cnt_d;

  cmd_t head;
  cmd_t wr_entry;
  logic empty;
  logic cmd_ready;
  logic push;
  logic cap;
  logic head_err;

  assign empty     = (count_q == '0);
  assign cmd_ready = (count_q != DepthCnt);
  assign head      = mem_q[rd_ptr_q];
  assign head_err  = ({1'b0, head.sel} >= NumOpsW);

  // Flush wins over both push and capture in the cycle it is sampled.
  assign push = bus.cmd_valid & cmd_ready & ~bus.flush;
  assign cap  = ~empty & (~res_valid_q | bus.res_ready) & ~bus.flush;

  assign wr_entry = '{a: bus.cmd_a, b: bus.cmd_b, sel: bus.cmd_sel, tag: bus.cmd_tag};

  assign bus.cmd_ready  = cmd_ready;
  assign bus.alu_a      = empty ? 8'h00 : head.a;
  assign bus.alu_b      = empty ? 8'h00 : head.b;
  assign bus.alu_sel    = empty ? 4'h0 : head.sel;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_tag    = res_tag_q;
  assign bus.res_err    = res_err_q;
  assign bus.issued_cnt = issued_cnt_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_tag_d    = res_tag_q;
    res_err_d    = res_err_q;
    issued_cnt_d = issued_cnt_q;

    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      res_valid_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (cap) begin
        rd_ptr_d     = rd_ptr_q + PtrOne;
        res_valid_d  = 1'b1;
        res_data_d   = head_err ? 8'h00 : bus.alu_out;
        res_tag_d    = head.tag;
        res_err_d    = head_err;
        issued_cnt_d = issued_cnt_q + 16'd1;
      end else if (res_valid_q && bus.res_ready) begin
        res_valid_d = 1'b0;
      end
      unique case ({push, cap})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= 8'h00;
      res_tag_q    <= '0;
      res_err_q    <= 1'b0;
      issued_cnt_q <= 16'h0000;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_tag_q    <= res_tag_d;
      res_err_q    <= res_err_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: vector table for single ops plus
// hand-written backpressure, flush and mid-stream reset sequences.
module tb_alu_cmd_sequencer;
  localparam int unsigned TAG_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.TAG_W(TAG_W)) bus ();

  alu_cmd_sequencer #(
    .DEPTH  (4),
    .TAG_W  (TAG_W),
    .NUM_OPS(9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // External ALU model driven by the sequencer's operand outputs.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] sel);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (sel)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return p[7:0];
      4'd3:    return {a[6:0], 1'b0};
      4'd4:    return {1'b0, a[7:1]};
      4'd5:    return {a[6:0], a[7]};
      4'd6:    return {a[0], a[7:1]};
      4'd7:    return a & b;
      4'd8:    return a | b;
      default: return 8'hA5;
    endcase
  endfunction

  always_comb bus.alu_out = alu_f(bus.alu_a, bus.alu_b, bus.alu_sel);

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [3:0] tag;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs [12];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   issued_exp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                           input logic [3:0] tag);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = sel;
    bus.cmd_tag   = tag;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{8'h0F, 8'h01, 4'd0, 4'd3,  8'h10, 1'b0};
    vecs[1]  = '{8'hFF, 8'h02, 4'd0, 4'd1,  8'h01, 1'b0};
    vecs[2]  = '{8'h00, 8'h01, 4'd1, 4'd2,  8'hFF, 1'b0};
    vecs[3]  = '{8'h10, 8'h11, 4'd2, 4'd4,  8'h10, 1'b0};
    vecs[4]  = '{8'h81, 8'h00, 4'd3, 4'd5,  8'h02, 1'b0};
    vecs[5]  = '{8'h81, 8'h00, 4'd4, 4'd6,  8'h40, 1'b0};
    vecs[6]  = '{8'h81, 8'h00, 4'd5, 4'd7,  8'h03, 1'b0};
    vecs[7]  = '{8'h81, 8'h00, 4'd6, 4'd8,  8'hC0, 1'b0};
    vecs[8]  = '{8'hF0, 8'h3C, 4'd7, 4'd9,  8'h30, 1'b0};
    vecs[9]  = '{8'hF0, 8'h0C, 4'd8, 4'hA,  8'hFC, 1'b0};
    vecs[10] = '{8'h05, 8'h06, 4'hC, 4'hB,  8'h00, 1'b1};
    vecs[11] = '{8'h05, 8'h06, 4'd0, 4'hC,  8'h0B, 1'b0};

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_sel   = '0;
    bus.cmd_tag   = '0;
    bus.res_ready = 1'b0;
    bus.flush     = 1'b0;
    #2;
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_tag", bus.res_tag, 0);
    chk("rst_res_err", bus.res_err, 0);
    chk("rst_issued", bus.issued_cnt, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_sel", bus.alu_sel, 0);
    tick();
    tick();
    rst = 1'b0;
    bus.res_ready = 1'b1;

    // Single-op vectors: push at edge N, result visible after edge N+1.
    for (int i = 0; i < 12; i++) begin
      drive_cmd(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].tag);
      tick();
      bus.cmd_valid = 1'b0;
      chk($sformatf("v%0d_lat_valid", i), bus.res_valid, 0);
      tick();
      issued_exp++;
      chk($sformatf("v%0d_valid", i), bus.res_valid, 1);
      chk($sformatf("v%0d_data", i), bus.res_data, vecs[i].exp_data);
      chk($sformatf("v%0d_tag", i), bus.res_tag, vecs[i].tag);
      chk($sformatf("v%0d_err", i), bus.res_err, vecs[i].exp_err);
      chk($sformatf("v%0d_issued", i), bus.issued_cnt, issued_exp);
    end
    tick();
    chk("tbl_drain_valid", bus.res_valid, 0);

    // Backpressure: 1 held + 4 queued, full FIFO ignores a further command.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_cmd(8'(i + 1), 8'(i + 1), 4'd0, 4'(i + 1));
      tick();
    end
    bus.cmd_valid = 1'b0;
    issued_exp++;
    chk("bp_full_ready", bus.cmd_ready, 0);
    chk("bp_held_valid", bus.res_valid, 1);
    chk("bp_held_tag", bus.res_tag, 1);
    chk("bp_held_data", bus.res_data, 2);
    drive_cmd(8'hEE, 8'hEE, 4'd0, 4'hF);
    tick();
    bus.cmd_valid = 1'b0;
    chk("bp_hold_ready", bus.cmd_ready, 0);
    chk("bp_hold_tag", bus.res_tag, 1);
    chk("bp_hold_data", bus.res_data, 2);
    bus.res_ready = 1'b1;
    for (int j = 2; j <= 5; j++) begin
      tick();
      issued_exp++;
      chk($sformatf("bp_r%0d_valid", j), bus.res_valid, 1);
      chk($sformatf("bp_r%0d_tag", j), bus.res_tag, j);
      chk($sformatf("bp_r%0d_data", j), bus.res_data, 2 * j);
    end
    chk("bp_empty_ready", bus.cmd_ready, 1);
    tick();
    chk("bp_drain_valid", bus.res_valid, 0);
    chk("bp_issued", bus.issued_cnt, issued_exp);

    // Flush with 3 queued + 1 held result.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(8'(8'h20 + i), 8'h00, 4'd8, 4'(6 + i));
      tick();
    end
    bus.cmd_valid = 1'b0;
    issued_exp++;
    chk("fl_pre_valid", bus.res_valid, 1);
    chk("fl_pre_tag", bus.res_tag, 6);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fl_valid", bus.res_valid, 0);
    chk("fl_ready", bus.cmd_ready, 1);
    chk("fl_issued", bus.issued_cnt, issued_exp);
    chk("fl_alu_a", bus.alu_a, 0);
    bus.res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("fl_stale%0d", k), bus.res_valid, 0);
    end
    drive_cmd(8'h03, 8'h04, 4'd2, 4'hA);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    issued_exp++;
    chk("fl_new_valid", bus.res_valid, 1);
    chk("fl_new_tag", bus.res_tag, 4'hA);
    chk("fl_new_data", bus.res_data, 8'h0C);
    chk("fl_new_issued", bus.issued_cnt, issued_exp);
    tick();

    // Asynchronous reset mid-stream.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(8'(i), 8'(i), 4'd7, 4'(i + 1));
      tick();
    end
    bus.cmd_valid = 1'b0;
    issued_exp++;
    chk("mr_pre_valid", bus.res_valid, 1);
    chk("mr_pre_ready", bus.cmd_ready, 1);
    chk("mr_pre_issued", bus.issued_cnt, issued_exp);
    #3;
    rst = 1'b1;
    #1;
    chk("mr_valid", bus.res_valid, 0);
    chk("mr_ready", bus.cmd_ready, 1);
    chk("mr_issued", bus.issued_cnt, 0);
    chk("mr_alu_a", bus.alu_a, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("mr_after_valid", bus.res_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
